// File: rtl/input_debounce2.sv
// Two-channel input conditioner: two-flop synchronizer, counter-based debounce and
// registered rise/fall strobes per channel. Channel A is index 0, channel B is index 1.
module input_debounce2 #(
  parameter int STABLE_CYCLES = 120000,
  parameter int CNT_W         = 17
) (
  input  logic CLK,
  input  logic RST,
  input  logic in_a,
  input  logic in_b,
  output logic a,
  output logic b,
  output logic rise_a,
  output logic fall_a,
  output logic rise_b,
  output logic fall_b
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] rise;
  logic [1:0] fall;

  assign raw = {in_b, in_a};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             out_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt;

    // s1 absorbs metastability; only s2 feeds the debounce decision.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
      end
    end

    // A run of STABLE_CYCLES consecutive mismatches commits the new level;
    // any agreement in between clears the run, so cnt never passes LAST.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt    <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (s2 == out_q) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt    <= '0;
          out_q  <= s2;
          rise_q <= s2;
          fall_q <= ~s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign lvl[g]  = out_q;
    assign rise[g] = rise_q;
    assign fall[g] = fall_q;
  end

  assign a      = lvl[0];
  assign b      = lvl[1];
  assign rise_a = rise[0];
  assign fall_a = fall[0];
  assign rise_b = rise[1];
  assign fall_b = fall[1];

endmodule

// File: tb/tb_input_debounce2.sv
// Directed bench for input_debounce2 with STABLE_CYCLES=4, CNT_W=3.
// Observed vector per cycle: {a, rise_a, fall_a, b, rise_b, fall_b}.
module tb_input_debounce2;

  localparam int SC = 4;
  localparam int CW = 3;
  localparam int W  = 6;

  localparam logic [W-1:0] IDLE   = 6'b000000;
  localparam logic [W-1:0] A_HI   = 6'b100000;
  localparam logic [W-1:0] A_RISE = 6'b110000;
  localparam logic [W-1:0] A_FALL = 6'b001000;
  localparam logic [W-1:0] B_HI   = 6'b000100;
  localparam logic [W-1:0] B_RISE = 6'b000110;
  localparam logic [W-1:0] B_FALL = 6'b000001;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic in_a = 1'b0;
  logic in_b = 1'b0;
  logic a, b, rise_a, fall_a, rise_b, fall_b;
  logic [W-1:0] obs;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  input_debounce2 #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .in_a   (in_a),
    .in_b   (in_b),
    .a      (a),
    .b      (b),
    .rise_a (rise_a),
    .fall_a (fall_a),
    .rise_b (rise_b),
    .fall_b (fall_b)
  );

  assign obs = {a, rise_a, fall_a, b, rise_b, fall_b};

  // Clock/reset block: 10-unit period, reset driven by the stimulus process.
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got=%b expected=%b", tag, $time, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // One expected vector per edge, sampled 1 unit after the rising edge.
  task automatic drain(input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  initial begin
    in_a = 1'b1;
    in_b = 1'b1;
    #1 RST = 1'b1;
    #1 check("reset_async", obs, IDLE);
    push(IDLE, 3);
    drain("reset_hold");

    // Release between edges: the next edge is edge 1, rise lands on edge 6.
    RST  = 1'b0;
    in_b = 1'b0;
    push(IDLE, 5); push(A_RISE, 1); push(A_HI, 3);
    drain("reset_release");

    in_a = 1'b0;
    push(A_HI, 5); push(A_FALL, 1); push(IDLE, 3);
    drain("clean_fall");

    in_a = 1'b1;
    push(IDLE, 5); push(A_RISE, 1); push(A_HI, 3);
    drain("clean_rise");

    for (int i = 0; i < 5; i++) begin
      in_b = 1'b1; push(A_HI, 2); drain("bounce");
      in_b = 1'b0; push(A_HI, 2); drain("bounce");
    end
    in_b = 1'b1;
    push(A_HI, 5); push(A_HI | B_RISE, 1); push(A_HI | B_HI, 3);
    drain("bounce_settle");

    in_a = 1'b0;
    push(A_HI | B_HI, 5); push(A_FALL | B_HI, 1); push(B_HI, 3);
    drain("thr_prep");

    // High for exactly SC-1 samples: no change.
    in_a = 1'b1; push(B_HI, 3);  drain("thr_3");
    in_a = 1'b0; push(B_HI, 10); drain("thr_3");

    // High for exactly SC samples: rise, then fall once low is stable.
    in_a = 1'b1; push(B_HI, 4); drain("thr_4");
    in_a = 1'b0;
    push(B_HI, 1); push(A_RISE | B_HI, 1); push(A_HI | B_HI, 3);
    push(A_FALL | B_HI, 1); push(B_HI, 2);
    drain("thr_4");

    in_b = 1'b0;
    push(B_HI, 5); push(B_FALL, 1); push(IDLE, 2);
    drain("b_fall");

    in_a = 1'b1;
    in_b = 1'b1;
    push(IDLE, 5); push(A_RISE | B_RISE, 1); push(A_HI | B_HI, 2);
    drain("simul_rise");

    // One-sample glitch on in_b while a is counting toward its fall.
    in_a = 1'b0;
    push(A_HI | B_HI, 1); drain("glitch");
    in_b = 1'b0;
    push(A_HI | B_HI, 1); drain("glitch");
    in_b = 1'b1;
    push(A_HI | B_HI, 3); push(A_FALL | B_HI, 1); push(B_HI, 3);
    drain("glitch");

    // Mid-count reset: two cycles counted, then an asynchronous pulse between edges.
    in_a = 1'b1;
    push(B_HI, 4); drain("midcnt_pre");
    #2 RST = 1'b1;
    #1 check("midcnt_async", obs, IDLE);
    #2 RST = 1'b0;
    push(IDLE, 5); push(A_RISE | B_RISE, 1); push(A_HI | B_HI, 2);
    drain("midcnt_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
